// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the three memory requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  mem_rdata,
    output ld_ack, ld_rdata, dm_ack, dm_rdata, if_ack, if_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr,
    output mem_rdata,
    input  ld_ack, ld_rdata, dm_ack, dm_rdata, if_ack, if_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: loader > starved fetch > data > fetch, one access at a time
// through ISSUE / WAIT (MEM_LAT cycles) / RESP. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  typedef enum logic [1:0] {GntLd, GntDm, GntIf} gnt_e;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic              cmd_we_q, cmd_we_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        streak_q, streak_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ld_ack_q, ld_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_cap;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cmd_we_d    = cmd_we_q;
    wait_cnt_d  = wait_cnt_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_ack_d    = 1'b0;
    ld_rdata_d  = ld_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rdata_d  = if_rdata_q;
    rd_cap      = cmd_we_q ? '0 : bus.mem_rdata;

    unique case (state_q)
      StIdle: begin
        if (bus.ld_req || bus.dm_req || bus.if_req) begin
          state_d  = StIssue;
          mem_en_d = 1'b1;
          if (bus.ld_req) begin
            gnt_d       = GntLd;
            cmd_we_d    = bus.ld_we;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
          end else if (bus.if_req && (streak_q == 4'(STARVE_MAX))) begin
            gnt_d       = GntIf;
            cmd_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end else if (bus.dm_req) begin
            gnt_d       = GntDm;
            cmd_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            // Only count data wins that actually made a fetch wait.
            if (bus.if_req && (streak_q < 4'(STARVE_MAX))) begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            gnt_d       = GntIf;
            cmd_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
          mem_we_d = cmd_we_d;
        end
      end
      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = 3'(MEM_LAT - 1);
      end
      StWait: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = StResp;
          case (gnt_q)
            GntLd: begin
              ld_rdata_d = rd_cap;
              ld_ack_d   = 1'b1;
            end
            GntDm: begin
              dm_rdata_d = rd_cap;
              dm_ack_d   = 1'b1;
            end
            default: begin
              if_rdata_d = rd_cap;
              if_ack_d   = 1'b1;
            end
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt_q       <= GntLd;
      cmd_we_q    <= 1'b0;
      wait_cnt_q  <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      ld_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cmd_we_q    <= cmd_we_d;
      wait_cnt_q  <= wait_cnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_ack_q    <= ld_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_ack_q    <= if_ack_d;
      ld_rdata_q  <= ld_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rdata_q  <= if_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the CPU core. It shares one synchronous RAM between three requesters: the external program loader, the CPU data load/store path and the CPU instruction fetch path. It drives one access at a time through a fixed ISSUE/WAIT/RESP sequence and returns read data to the winning port with a one-cycle acknowledge. It sits between the core's fetch and data units and the memory instance, inside the `cpu` top.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 16: memory word width.
- `MEM_LAT`, 1: memory read latency in cycles, counted from the `mem_en` cycle. Legal range 1–7.
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch waits. Legal range 1–15.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ld_req` in 1, `ld_we` in 1, `ld_addr` in ADDR_W, `ld_wdata` in DATA_W: loader request.
- `ld_ack` out 1, `ld_rdata` out DATA_W: loader response.
- `dm_req` in 1, `dm_we` in 1, `dm_addr` in ADDR_W, `dm_wdata` in DATA_W: data path request.
- `dm_ack` out 1, `dm_rdata` out DATA_W: data path response.
- `if_req` in 1, `if_addr` in ADDR_W: fetch request (read only).
- `if_ack` out 1, `if_rdata` out DATA_W: fetch response.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory command.
- `mem_rdata` in DATA_W: memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Every output is a register. Reset value of every output is 0; state returns to IDLE; the streak counter clears.
- Request protocol:
  - A requester holds `*_req`, address, `we` and `wdata` stable until it samples `*_ack`=1.
  - It drops `*_req` in the cycle after the ack, or keeps it high to issue a new request.
  - If a requester drops `*_req` before its ack, the arbiter still completes the access and still pulses the ack.
- IDLE: at each edge, if any `*_req` is high, the arbiter picks a winner, latches its command and moves to ISSUE. Otherwise it stays in IDLE.
- Winner priority:
  1. The loader always wins.
  2. Otherwise, fetch wins if `if_req`=1 and the streak count equals `STARVE_MAX`.
  3. Otherwise data wins if `dm_req`=1.
  4. Otherwise fetch wins.
- Streak counter (4 bits):
  - Increments on a data grant made while `if_req`=1. It saturates at `STARVE_MAX`.
  - Clears on any fetch grant.
  - Unchanged by loader grants.
- ISSUE (1 cycle): `mem_en`=1, and `mem_addr`/`mem_we`/`mem_wdata` carry the latched command. A fetch command has `we`=0. Next state is WAIT.
- WAIT (`MEM_LAT` cycles, down-counter): `mem_en`=0.
  - At the edge ending the last WAIT cycle, `mem_rdata` is captured into the winner's `*_rdata` register. For a write, 0 is captured instead.
  - Next state is RESP.
- RESP (1 cycle): the winner's `*_ack`=1; all other acks are 0. Next state is IDLE.
- `*_rdata` registers of the ports that did not win hold their previous values.
- Reset mid-access (any state): the access is abandoned, no ack is issued, and `mem_en` is 0 in the cycle after the reset edge. A write in progress at ISSUE is not repeated.

## Timing
- Request sampled in IDLE in cycle 0:
  - `mem_en` in cycle 1.
  - `mem_rdata` valid in cycle 1+`MEM_LAT`.
  - `*_ack` and `*_rdata` valid in cycle 2+`MEM_LAT`.
  - IDLE again in cycle 3+`MEM_LAT`.
- Occupancy is 3+`MEM_LAT` cycles per access; there is no overlap or pipelining.
- A request arriving while `busy`=1 waits and is arbitrated at the next IDLE cycle.
- Requests arriving simultaneously are resolved only by the priority rules; no queueing order is kept.
- At most one `*_ack` is high in any cycle. No ack lasts longer than one cycle.

## Test plan
- Reset values:
  - Stimulus: `reset`=1 for 2 cycles with all requests high.
  - Required: all outputs 0 throughout; first `mem_en` in the second cycle after reset falls.
- Basic fetch read, `MEM_LAT`=1:
  - Stimulus: RAM[0x12]=0xBEEF; `if_req`=1 with `if_addr`=0x12 in cycle 0.
  - Required: `mem_en`=1 and `mem_addr`=0x12 in cycle 1; `if_ack`=1 and `if_rdata`=0xBEEF in cycle 3; `busy` low in cycle 4.
- Write then read:
  - Stimulus: `dm_we`=1, `dm_addr`=0x05, `dm_wdata`=0x1234; then a data read of 0x05.
  - Required: `mem_we`=1 in the write's ISSUE cycle; write ack with `dm_rdata`=0; read returns `dm_rdata`=0x1234.
- Priority:
  - Stimulus: `ld_req`, `dm_req` and `if_req` all raised in cycle 0 and held until each is acked.
  - Required: grants in order ld, dm, if; acks in cycles 3, 7, 11.
- Starvation guard:
  - Stimulus: `STARVE_MAX`=2; `dm_req` and `if_req` held high continuously, with the data requester re-requesting immediately after each ack.
  - Required: grant sequence dm, dm, if, dm, dm, if.
- Longer latency and reset mid-access:
  - Stimulus: `MEM_LAT`=3, fetch read issued in cycle 0.
  - Required: `if_ack` in cycle 5.
  - Stimulus: repeat the read, asserting `reset` in the second WAIT cycle.
  - Required: no `if_ack` is issued; `busy`=0 after the reset edge.
